// File: rtl/demux_l2_lane_ctrl.sv
// Receive-side layer-2 lane steering for the 1-to-2 byte demux: alternates accepted bytes
// between two one-entry lane registers, realigning to lane 0 after an idle gap.
// Optional per-lane delivered-byte counters are built when DEMUX_L2_STATS_EN is defined.
module demux_l2_lane_ctrl #(
    parameter int unsigned IDLE_RESYNC = 32'd4
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       in_ready,
    input  logic       ready0,
    input  logic       ready1,
    output logic       validout0,
    output logic       validout1,
    output logic [7:0] dataout0_demuxL2,
    output logic [7:0] dataout1_demuxL2,
    output logic       lane_ptr,
    output logic       resync,
    output logic [7:0] bytes0,
    output logic [7:0] bytes1
);

    localparam int unsigned GW = $clog2(IDLE_RESYNC + 32'd1);
    localparam logic [GW-1:0] CNT_ONE   = GW'(32'd1);
    localparam logic [GW-1:0] CNT_MAX   = {GW{1'b1}};
    localparam logic [GW-1:0] RESYNC_M1 = GW'(IDLE_RESYNC - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [GW-1:0]   gap_cnt_r;
    logic [GW-1:0]   gap_cnt_nxt_s;
    logic            lane_ptr_r;
    logic            lane_ptr_nxt_s;
    logic            resync_r;
    logic            resync_nxt_s;
    logic            to_idle_s;

    logic            validout0_r;
    logic            validout1_r;
    logic [7:0]      dataout0_r;
    logic [7:0]      dataout1_r;

    logic            in_ready_s;
    logic            accept_s;
    logic            fill0_s;
    logic            fill1_s;
    logic            drain0_s;
    logic            drain1_s;

    // Upstream handshake: the target lane must be empty or emptying this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (!reset_L) begin
            in_ready_s = 1'b0;
        end else if (lane_ptr_r) begin
            in_ready_s = !validout1_r || ready1;
        end else begin
            in_ready_s = !validout0_r || ready0;
        end
    end

    assign accept_s = valid_in && in_ready_s;
    assign fill0_s  = accept_s && !lane_ptr_r;
    assign fill1_s  = accept_s && lane_ptr_r;
    assign drain0_s = validout0_r && ready0;
    assign drain1_s = validout1_r && ready1;

    // FSM state and pointer bookkeeping register.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            state_r    <= ST_IDLE;
            gap_cnt_r  <= {GW{1'b0}};
            lane_ptr_r <= 1'b0;
            resync_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            gap_cnt_r  <= gap_cnt_nxt_s;
            lane_ptr_r <= lane_ptr_nxt_s;
            resync_r   <= resync_nxt_s;
        end
    end

    // FSM next-state decode; a stalled valid_in still counts as activity.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (valid_in) begin
                    state_nxt_s = ST_RUN;
                end else if (IDLE_RESYNC == 32'd1) begin
                    // The first idle cycle already reaches a threshold of one.
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_GAP: begin
                if (valid_in) begin
                    state_nxt_s = ST_RUN;
                end else if (gap_cnt_r >= RESYNC_M1) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: saturating gap counter, lane pointer and realign pulse.
    always_comb begin
        to_idle_s      = 1'b0;
        gap_cnt_nxt_s  = {GW{1'b0}};
        lane_ptr_nxt_s = lane_ptr_r;
        resync_nxt_s   = 1'b0;

        if ((state_r != ST_IDLE) && (state_nxt_s == ST_IDLE)) begin
            to_idle_s = 1'b1;
        end else begin
            to_idle_s = 1'b0;
        end

        if (state_nxt_s == ST_GAP) begin
            if (state_r != ST_GAP) begin
                gap_cnt_nxt_s = CNT_ONE;
            end else if (gap_cnt_r != CNT_MAX) begin
                gap_cnt_nxt_s = gap_cnt_r + CNT_ONE;
            end else begin
                gap_cnt_nxt_s = gap_cnt_r;
            end
        end else begin
            gap_cnt_nxt_s = {GW{1'b0}};
        end

        // Realign only happens on idle cycles, so it never collides with an accept.
        if (to_idle_s) begin
            lane_ptr_nxt_s = 1'b0;
        end else if (accept_s) begin
            lane_ptr_nxt_s = !lane_ptr_r;
        end else begin
            lane_ptr_nxt_s = lane_ptr_r;
        end

        if (to_idle_s && lane_ptr_r) begin
            resync_nxt_s = 1'b1;
        end else begin
            resync_nxt_s = 1'b0;
        end
    end

    // Lane 0 output register: refill wins over drain in the same cycle.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            validout0_r <= 1'b0;
            dataout0_r  <= 8'h00;
        end else if (fill0_s) begin
            validout0_r <= 1'b1;
            dataout0_r  <= data_in;
        end else if (drain0_s) begin
            validout0_r <= 1'b0;
        end
    end

    // Lane 1 output register: refill wins over drain in the same cycle.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            validout1_r <= 1'b0;
            dataout1_r  <= 8'h00;
        end else if (fill1_s) begin
            validout1_r <= 1'b1;
            dataout1_r  <= data_in;
        end else if (drain1_s) begin
            validout1_r <= 1'b0;
        end
    end

`ifdef DEMUX_L2_STATS_EN
    logic [7:0] bytes0_r;
    logic [7:0] bytes1_r;

    // Delivered-byte counters, wrapping at 255.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            bytes0_r <= 8'h00;
            bytes1_r <= 8'h00;
        end else begin
            if (drain0_s) begin
                bytes0_r <= bytes0_r + 8'd1;
            end
            if (drain1_s) begin
                bytes1_r <= bytes1_r + 8'd1;
            end
        end
    end

    assign bytes0 = bytes0_r;
    assign bytes1 = bytes1_r;
`else
    assign bytes0 = 8'h00;
    assign bytes1 = 8'h00;
`endif

    assign in_ready         = in_ready_s;
    assign validout0        = validout0_r;
    assign validout1        = validout1_r;
    assign dataout0_demuxL2 = dataout0_r;
    assign dataout1_demuxL2 = dataout1_r;
    assign lane_ptr         = lane_ptr_r;
    assign resync           = resync_r;

endmodule

// File: tb/tb_demux_l2_lane_ctrl.sv
// Directed bench for demux_l2_lane_ctrl (IDLE_RESYNC = 4); expected values are hand-computed.
module tb_demux_l2_lane_ctrl;

    logic       clk_4f;
    logic       reset_L;
    logic       valid_in;
    logic [7:0] data_in;
    logic       in_ready;
    logic       ready0;
    logic       ready1;
    logic       validout0;
    logic       validout1;
    logic [7:0] dataout0_demuxL2;
    logic [7:0] dataout1_demuxL2;
    logic       lane_ptr;
    logic       resync;
    logic [7:0] bytes0;
    logic [7:0] bytes1;

    int vec_cnt;
    int err_cnt;

`ifdef DEMUX_L2_STATS_EN
    localparam logic [31:0] EXP_BYTES = 32'd3;
`else
    localparam logic [31:0] EXP_BYTES = 32'd0;
`endif

    demux_l2_lane_ctrl #(.IDLE_RESYNC(32'd4)) dut (
        .clk_4f           (clk_4f),
        .reset_L          (reset_L),
        .valid_in         (valid_in),
        .data_in          (data_in),
        .in_ready         (in_ready),
        .ready0           (ready0),
        .ready1           (ready1),
        .validout0        (validout0),
        .validout1        (validout1),
        .dataout0_demuxL2 (dataout0_demuxL2),
        .dataout1_demuxL2 (dataout1_demuxL2),
        .lane_ptr         (lane_ptr),
        .resync           (resync),
        .bytes0           (bytes0),
        .bytes1           (bytes1)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_4f = 1'b0;
        forever #5 clk_4f = ~clk_4f;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    // Present a byte, check in_ready before the edge, then take the edge.
    task automatic send(input logic [7:0] b, input logic exp_rdy, input string tag);
        valid_in = 1'b1;
        data_in  = b;
        #1;
        check_val(tag, {31'd0, in_ready}, {31'd0, exp_rdy});
        tick();
    endtask

    task automatic idle_cycles(input int n);
        valid_in = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
        end
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        ready0   = 1'b1;
        ready1   = 1'b1;

        // Reset state
        #1;
        check_val("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check_val("rst_validout0", {31'd0, validout0}, 32'd0);
        check_val("rst_validout1", {31'd0, validout1}, 32'd0);
        check_val("rst_data0", {24'd0, dataout0_demuxL2}, 32'h00);
        check_val("rst_data1", {24'd0, dataout1_demuxL2}, 32'h00);
        check_val("rst_lane_ptr", {31'd0, lane_ptr}, 32'd0);
        check_val("rst_resync", {31'd0, resync}, 32'd0);
        check_val("rst_bytes0", {24'd0, bytes0}, 32'd0);
        reset_L = 1'b1;

        // Stream 10..15 with both lanes draining every cycle
        for (int i = 0; i < 6; i++) begin
            send(8'h10 + 8'(i), 1'b1, "stream_in_ready");
            if ((i % 2) == 0) begin
                check_val("stream_valid0", {31'd0, validout0}, 32'd1);
                check_val("stream_data0", {24'd0, dataout0_demuxL2}, 32'h10 + 32'(i));
            end else begin
                check_val("stream_valid1", {31'd0, validout1}, 32'd1);
                check_val("stream_data1", {24'd0, dataout1_demuxL2}, 32'h10 + 32'(i));
            end
            check_val("stream_lane_ptr", {31'd0, lane_ptr}, 32'((i + 1) % 2));
        end
        idle_cycles(1);
        check_val("stream_drained0", {31'd0, validout0}, 32'd0);
        check_val("stream_drained1", {31'd0, validout1}, 32'd0);
        check_val("stream_hold_data1", {24'd0, dataout1_demuxL2}, 32'h15);
        check_val("stream_bytes0", {24'd0, bytes0}, EXP_BYTES);
        check_val("stream_bytes1", {24'd0, bytes1}, EXP_BYTES);
        // Idle gap with pointer already on lane 0: no realign pulse
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("even_gap_no_resync", {31'd0, resync}, 32'd0);
        end

        // Back-pressure on lane 1
        send(8'hA0, 1'b1, "bp_a0_rdy");
        send(8'hA1, 1'b1, "bp_a1_rdy");
        ready1 = 1'b0;
        send(8'hA2, 1'b1, "bp_a2_rdy");
        check_val("bp_a2_lane0", {24'd0, dataout0_demuxL2}, 32'hA2);
        check_val("bp_a1_held", {24'd0, dataout1_demuxL2}, 32'hA1);
        send(8'hA3, 1'b0, "bp_a3_stall");
        check_val("bp_stall_ptr", {31'd0, lane_ptr}, 32'd1);
        check_val("bp_stall_valid1", {31'd0, validout1}, 32'd1);
        check_val("bp_stall_data1", {24'd0, dataout1_demuxL2}, 32'hA1);
        check_val("bp_lane0_drained", {31'd0, validout0}, 32'd0);
        ready1 = 1'b1;
        send(8'hA3, 1'b1, "bp_a3_release");
        check_val("bp_refill_valid1", {31'd0, validout1}, 32'd1);
        check_val("bp_refill_data1", {24'd0, dataout1_demuxL2}, 32'hA3);
        check_val("bp_refill_ptr", {31'd0, lane_ptr}, 32'd0);
        idle_cycles(6);

        // Odd pointer, 4 idle cycles: realign with one resync pulse
        send(8'hB0, 1'b1, "rs_b0");
        send(8'hB1, 1'b1, "rs_b1");
        send(8'hB2, 1'b1, "rs_b2");
        check_val("rs_ptr_odd", {31'd0, lane_ptr}, 32'd1);
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("rs_early_resync", {31'd0, resync}, 32'd0);
            check_val("rs_early_ptr", {31'd0, lane_ptr}, 32'd1);
        end
        tick();
        check_val("rs_pulse", {31'd0, resync}, 32'd1);
        check_val("rs_ptr_realigned", {31'd0, lane_ptr}, 32'd0);
        tick();
        check_val("rs_pulse_one_cycle", {31'd0, resync}, 32'd0);
        send(8'hC0, 1'b1, "rs_c0");
        check_val("rs_c0_lane0_valid", {31'd0, validout0}, 32'd1);
        check_val("rs_c0_lane0_data", {24'd0, dataout0_demuxL2}, 32'hC0);

        // Odd pointer, only 3 idle cycles: no realign
        send(8'hC1, 1'b1, "nr_c1");
        send(8'hC2, 1'b1, "nr_c2");
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("nr_no_resync", {31'd0, resync}, 32'd0);
        end
        send(8'hD0, 1'b1, "nr_d0");
        check_val("nr_d0_lane1_valid", {31'd0, validout1}, 32'd1);
        check_val("nr_d0_lane1_data", {24'd0, dataout1_demuxL2}, 32'hD0);
        check_val("nr_d0_ptr", {31'd0, lane_ptr}, 32'd0);
        check_val("nr_d0_resync", {31'd0, resync}, 32'd0);
        idle_cycles(1);

        // Reset with both lanes holding data
        ready0 = 1'b0;
        ready1 = 1'b0;
        send(8'hE0, 1'b1, "mr_e0");
        send(8'hE1, 1'b1, "mr_e1");
        check_val("mr_both_valid", {30'd0, validout1, validout0}, 32'd3);
        valid_in = 1'b0;
        reset_L  = 1'b0;
        #1;
        check_val("mr_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        check_val("mr_validout0", {31'd0, validout0}, 32'd0);
        check_val("mr_validout1", {31'd0, validout1}, 32'd0);
        check_val("mr_data0", {24'd0, dataout0_demuxL2}, 32'h00);
        check_val("mr_lane_ptr", {31'd0, lane_ptr}, 32'd0);
        check_val("mr_bytes0", {24'd0, bytes0}, 32'd0);
        check_val("mr_bytes1", {24'd0, bytes1}, 32'd0);
        tick();
        check_val("mr_in_ready_held", {31'd0, in_ready}, 32'd0);
        reset_L = 1'b1;
        #1;
        check_val("mr_in_ready_release", {31'd0, in_ready}, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
